// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Fetch, data and backend signal bundle for the unified memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction fetch side
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_kill;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;

    // Load/store side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    // Backend memory side
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, i_kill,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output i_done, i_rdata, i_stall,
        output d_done, d_rdata, d_stall,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    // Pipeline + backend view
    modport master (
        output i_req, i_addr, i_kill,
        output d_req, d_we, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  i_done, i_rdata, i_stall,
        input  d_done, d_rdata, d_stall,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one variable-latency memory port between fetch and data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire                 clk,
    input  wire                 reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int          CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);
    localparam logic        OWN_I   = 1'b0;
    localparam logic        OWN_D   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       starve_q, starve_d;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                mem_valid_q;
    logic                kill_q;
    logic                i_done_q;
    logic                d_done_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic w_i_eligible;
    logic w_starved;
    logic w_grant_d;
    logic w_grant_i;
    logic w_accept;
    logic w_complete;
    logic w_kill_now;

    always_comb begin
        w_i_eligible = bus.i_req & ~bus.i_kill;
        w_starved    = w_i_eligible & (starve_q == C_LIMIT);
        w_grant_d    = (state_q == ST_IDLE) & bus.d_req & ~w_starved;
        w_grant_i    = (state_q == ST_IDLE) & w_i_eligible & ~w_grant_d;
        w_accept     = (state_q == ST_ISSUE) & bus.mem_ready;
        // Response may coincide with the accept cycle
        w_complete   = (w_accept | (state_q == ST_WAIT)) & bus.mem_rvalid;
        w_kill_now   = (owner_q == OWN_I) & (state_q != ST_IDLE) & bus.i_kill;
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.i_req) begin
            starve_d = '0;
        end else if (w_grant_i) begin
            starve_d = '0;
        end else if (w_grant_d && (starve_q != C_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_grant_d || w_grant_i) state_d = ST_ISSUE;
            ST_ISSUE: if (w_complete)             state_d = ST_IDLE;
                      else if (w_accept)          state_d = ST_WAIT;
            ST_WAIT:  if (w_complete)             state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            owner_q     <= OWN_I;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_valid_q <= 1'b0;
            kill_q      <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;

            if (w_grant_d) begin
                owner_q     <= OWN_D;
                we_q        <= bus.d_we;
                addr_q      <= bus.d_addr;
                wdata_q     <= bus.d_wdata;
                mem_valid_q <= 1'b1;
            end else if (w_grant_i) begin
                owner_q     <= OWN_I;
                we_q        <= 1'b0;
                addr_q      <= bus.i_addr;
                wdata_q     <= '0;
                mem_valid_q <= 1'b1;
            end

            if (w_accept) begin
                mem_valid_q <= 1'b0;
            end

            if (w_kill_now) begin
                kill_q <= 1'b1;
            end

            // A killed fetch still drains its backend response, silently
            if (w_complete) begin
                kill_q <= 1'b0;
                if (owner_q == OWN_D) begin
                    d_done_q <= 1'b1;
                    if (!we_q) begin
                        d_rdata_q <= bus.mem_rdata;
                    end
                end else if (!(kill_q || bus.i_kill)) begin
                    i_done_q  <= 1'b1;
                    i_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_stall   = bus.i_req & ~i_done_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard bench for mem_port_arbiter with a backend model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    int          n_vec      = 0;
    int          n_err      = 0;
    int          cyc        = 0;
    int          i_done_cnt = 0;
    logic [31:0] last_ld    = 32'h0;

    int          cfg_ready  = 0;
    int          cfg_rv     = 1;
    bit          bk_flush   = 1'b0;
    bit          stray      = 1'b0;
    logic [31:0] mem_model [logic [31:0]];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Backend: ready after cfg_ready stalled cycles, response cfg_rv cycles after accept
    initial begin
        int          wait_cnt  = 0;
        int          resp_cnt  = -1;
        logic [31:0] resp_data = 32'h0;
        bit          hold      = 1'b0;
        logic [31:0] h_addr    = 32'h0;
        logic [31:0] h_wdata   = 32'h0;
        logic        h_we      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (bk_flush) begin
                resp_cnt = -1;
                wait_cnt = 0;
                hold     = 1'b0;
                bk_flush = 1'b0;
            end
            if (stray) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'h5A5A5A5A;
                stray          = 1'b0;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = resp_data;
                    resp_cnt       = -1;
                end
            end
            if (hold) begin
                check("hold_mem_valid", 32'(bus.mem_valid), 32'd1);
                check("hold_mem_addr",  bus.mem_addr,  h_addr);
                check("hold_mem_we",    32'(bus.mem_we), 32'(h_we));
                check("hold_mem_wdata", bus.mem_wdata, h_wdata);
            end
            bus.mem_ready = bus.mem_valid && (wait_cnt >= cfg_ready);
            if (bus.mem_valid && !bus.mem_ready) begin
                wait_cnt++;
                hold    = 1'b1;
                h_addr  = bus.mem_addr;
                h_wdata = bus.mem_wdata;
                h_we    = bus.mem_we;
            end else begin
                hold = 1'b0;
            end
            if (bus.mem_ready) begin
                wait_cnt = 0;
                if (bus.mem_we) begin
                    mem_model[bus.mem_addr] = bus.mem_wdata;
                    resp_data = 32'h0;
                end else if (mem_model.exists(bus.mem_addr)) begin
                    resp_data = mem_model[bus.mem_addr];
                end else begin
                    resp_data = 32'h0BAD0BAD;
                end
                if (cfg_rv == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = resp_data;
                end else begin
                    resp_cnt = cfg_rv;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.i_done) begin
                i_done_cnt++;
                check("i_stall_in_done", 32'(bus.i_stall), 32'd0);
                if (iq.size() == 0) begin
                    check("i_done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = iq.pop_front();
                    check("i_rdata", bus.i_rdata, e.data);
                    if (e.cyc >= 0) check("i_done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.d_done) begin
                check("d_stall_in_done", 32'(bus.d_stall), 32'd0);
                if (dq.size() == 0) begin
                    check("d_done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = dq.pop_front();
                    check("d_rdata", bus.d_rdata, e.data);
                    if (e.cyc >= 0) check("d_done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic start_fetch(input logic [31:0] a, input logic [31:0] exp_d, input int lat);
        exp_t e;
        bus.i_addr = a;
        bus.i_req  = 1'b1;
        e.data = exp_d;
        e.cyc  = (lat < 0) ? -1 : cyc + lat;
        iq.push_back(e);
    endtask

    task automatic finish_fetch();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.i_done && t < 200);
        if (!bus.i_done) check("i_done_timeout", 32'd0, 32'd1);
        bus.i_req = 1'b0;
    endtask

    task automatic start_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_d, input int lat);
        exp_t e;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_req   = 1'b1;
        if (!we) last_ld = exp_d;
        e.data = last_ld;
        e.cyc  = (lat < 0) ? -1 : cyc + lat;
        dq.push_back(e);
    endtask

    task automatic finish_data();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.d_done && t < 200);
        if (!bus.d_done) check("d_done_timeout", 32'd0, 32'd1);
        bus.d_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_done"},    32'(bus.i_done),    32'd0);
        check({tag, "_d_done"},    32'(bus.d_done),    32'd0);
        check({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        check({tag, "_i_rdata"},   bus.i_rdata,        32'd0);
        check({tag, "_d_rdata"},   bus.d_rdata,        32'd0);
        check({tag, "_i_stall"},   32'(bus.i_stall),   32'd0);
        check({tag, "_d_stall"},   32'(bus.d_stall),   32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sdat [5];
        int          n_before;
        sdat = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'hE4E4E4E4};
        mem_model[32'h000] = 32'h00500093;
        mem_model[32'h004] = 32'h00A00113;
        mem_model[32'h008] = 32'h00B00193;
        mem_model[32'h040] = 32'h11111111;
        mem_model[32'h080] = 32'h22222222;
        mem_model[32'h100] = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) mem_model[32'h200 + 32'(4 * k)] = sdat[k];

        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_kill = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, zero-wait backend
        start_fetch(32'h0, 32'h00500093, 3);
        @(negedge clk);
        check("t1_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("t1_mem_addr",  bus.mem_addr, 32'h0);
        check("t1_i_stall_c1", 32'(bus.i_stall), 32'd1);
        @(negedge clk);
        check("t1_i_stall_c2", 32'(bus.i_stall), 32'd1);
        finish_fetch();
        repeat (2) @(negedge clk);

        // Simultaneous requests: data first, fetch issued in the data done cycle
        start_fetch(32'h4, 32'h00A00113, 6);
        start_data(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        fork
            finish_fetch();
            finish_data();
        join
        repeat (2) @(negedge clk);

        // Starvation guard: four data grants, then the waiting fetch
        start_fetch(32'h8, 32'h00B00193, 15);
        fork
            finish_fetch();
            begin
                for (int k = 0; k < 5; k++) begin
                    start_data(1'b0, 32'h200 + 32'(4 * k), 32'h0, sdat[k], (k < 4) ? 3 : 6);
                    finish_data();
                end
            end
        join
        repeat (2) @(negedge clk);

        // Stalled backend: store then read-back
        cfg_ready = 3;
        cfg_rv    = 2;
        start_data(1'b1, 32'h300, 32'hCAFEF00D, 32'h0, 7);
        finish_data();
        start_data(1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 7);
        finish_data();
        repeat (2) @(negedge clk);

        // Kill during WAIT, redirect to 0x80
        cfg_ready = 0;
        cfg_rv    = 3;
        bus.i_addr = 32'h40;
        bus.i_req  = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_kill = 1'b1;
        start_fetch(32'h80, 32'h22222222, 8);
        @(negedge clk);
        bus.i_kill = 1'b0;
        finish_fetch();
        repeat (2) @(negedge clk);

        // Kill in the cycle the done would be registered
        cfg_rv   = 1;
        n_before = i_done_cnt;
        bus.i_addr = 32'h40;
        bus.i_req  = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_kill = 1'b1;
        bus.i_req  = 1'b0;
        @(negedge clk);
        bus.i_kill = 1'b0;
        repeat (4) @(negedge clk);
        check("kill_at_done_no_i_done", 32'(i_done_cnt), 32'(n_before));

        // Reset while waiting, stray response afterwards
        cfg_rv   = 3;
        n_before = i_done_cnt;
        bus.i_addr = 32'h40;
        bus.i_req  = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        bus.i_req = 1'b0;
        bk_flush = 1'b1;
        @(negedge clk);
        check_all_zero("rst_wait");
        reset = 1'b0;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stray_i_done_cnt", 32'(i_done_cnt), 32'(n_before));
        check("rst_stray_i_rdata",    bus.i_rdata, 32'h0);
        check("rst_stray_mem_valid",  32'(bus.mem_valid), 32'd0);
        last_ld = 32'h0;
        cfg_rv  = 1;
        start_fetch(32'h0, 32'h00500093, 3);
        finish_fetch();
        repeat (3) @(negedge clk);

        check("i_queue_drained", 32'(iq.size()), 32'd0);
        check("d_queue_drained", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
